// File: rtl/lift_req_queue.sv
// Hall-call request queue feeding the lift controller: press detection, dedup, FIFO of call codes.
// Optional macro LIFTQ_SERVED_CNT_EN adds a 16-bit served-request counter output.
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       btn,
  input  logic             done,
  output logic [2:0]       req,
  output logic             qEmpty,
  output logic [5:0]       pending,
`ifdef LIFTQ_SERVED_CNT_EN
  output logic [15:0]      served_cnt,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: req is valid whenever qEmpty=0; a rising edge of done while
  // non-empty pops the head; done edges while empty are dropped.

  function automatic logic [2:0] bit_to_code(input logic [5:0] oh);
    logic [2:0] code;
    code = 3'b000;
    case (oh)
      6'b000001: code = 3'b001;
      6'b000010: code = 3'b010;
      6'b000100: code = 3'b011;
      6'b001000: code = 3'b110;
      6'b010000: code = 3'b111;
      6'b100000: code = 3'b100;
      default:   code = 3'b000;
    endcase
    return code;
  endfunction

  function automatic logic [5:0] code_to_bit(input logic [2:0] code);
    logic [5:0] oh;
    oh = 6'b000000;
    case (code)
      3'b001:  oh = 6'b000001;
      3'b010:  oh = 6'b000010;
      3'b011:  oh = 6'b000100;
      3'b110:  oh = 6'b001000;
      3'b111:  oh = 6'b010000;
      3'b100:  oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

  logic [5:0]       btn_q;
  logic             done_q;
  logic [5:0]       arm_q, arm_d;
  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       fifo_bits;
  logic [5:0]       new_press;
  logic [5:0]       push_oh;
  logic             empty, push, pop;

  always_comb begin
    fifo_bits = 6'b000000;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        fifo_bits = fifo_bits | code_to_bit(mem_q[rd_ptr_q + PTR_W'(i)]);
      end
    end
  end

  always_comb begin
    empty     = (count_q == '0);
    pending   = arm_q | fifo_bits;
    new_press = btn & ~btn_q & ~pending;
    pop       = done & ~done_q & ~empty;
    // Lowest-index armed call wins the single push slot this cycle.
    push_oh   = arm_q & (~arm_q + 6'd1);
    push      = (arm_q != 6'b000000) && (count_q != CNT_W'(DEPTH));
    arm_d     = (push ? (arm_q & ~push_oh) : arm_q) | new_press;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // done_q resets high so a done already asserted at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q    <= 6'b000000;
      done_q   <= 1'b1;
      arm_q    <= 6'b000000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'b000;
    end else begin
      btn_q   <= btn;
      done_q  <= done;
      arm_q   <= arm_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bit_to_code(push_oh);
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

`ifdef LIFTQ_SERVED_CNT_EN
  logic [15:0] served_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   served_q <= 16'h0000;
    else if (pop) served_q <= served_q + 16'h0001;
  end
  assign served_cnt = served_q;
`endif

  assign qEmpty = empty;
  assign req    = empty ? 3'b000 : mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: tb/tb_lift_req_queue.sv
// Bench for lift_req_queue: directed scenarios plus random presses/done pulses against a queue model.
module tb_lift_req_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]       btn = 6'b0;
  logic             done = 1'b0;
  logic [2:0]       req;
  logic             qEmpty;
  logic [5:0]       pending;
  logic [CNT_W-1:0] count;
`ifdef LIFTQ_SERVED_CNT_EN
  logic [15:0]      served_cnt;
`endif

  lift_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .done(done),
    .req(req),
    .qEmpty(qEmpty),
    .pending(pending),
`ifdef LIFTQ_SERVED_CNT_EN
    .served_cnt(served_cnt),
`endif
    .count(count)
  );

  // ---------------- behavioural model ----------------
  logic [2:0]  lut [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
  logic [2:0]  exp_q [$];
  logic [5:0]  m_arm;
  logic [5:0]  m_btn_prev;
  logic        m_done_prev;
  logic [15:0] m_served;
  int          total = 0;
  int          bad = 0;

  function automatic logic [5:0] lamp_of(input logic [2:0] code);
    logic [5:0] r;
    r = 6'b0;
    for (int b = 0; b < 6; b++) if (lut[b] == code) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [5:0] model_pending();
    logic [5:0] r;
    r = m_arm;
    foreach (exp_q[k]) r = r | lamp_of(exp_q[k]);
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_arm       = 6'b0;
    m_btn_prev  = 6'b0;
    m_done_prev = 1'b1;
    m_served    = 16'h0;
  endtask

  task automatic model_edge();
    logic [5:0] presses;
    bit         do_pop;
    presses = btn & ~m_btn_prev & ~model_pending();
    do_pop  = done && !m_done_prev && (exp_q.size() > 0);
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_served = m_served + 16'h1;
    end
    if (m_arm != 6'b0 && exp_q.size() < DEPTH) begin
      for (int b = 0; b < 6; b++) begin
        if (m_arm[b]) begin
          exp_q.push_back(lut[b]);
          m_arm[b] = 1'b0;
          break;
        end
      end
    end
    m_arm       = m_arm | presses;
    m_btn_prev  = btn;
    m_done_prev = done;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [2:0] e_req;
    e_req = (exp_q.size() == 0) ? 3'b000 : exp_q[0];
    check("req", 32'(req), 32'(e_req));
    check("qEmpty", 32'(qEmpty), 32'(exp_q.size() == 0));
    check("pending", 32'(pending), 32'(model_pending()));
    check("count", 32'(count), 32'(exp_q.size()));
`ifdef LIFTQ_SERVED_CNT_EN
    check("served_cnt", 32'(served_cnt), 32'(m_served));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_lit(input string tag);
    check({tag, "_req"}, 32'(req), 32'h0);
    check({tag, "_qEmpty"}, 32'(qEmpty), 32'h1);
    check({tag, "_pending"}, 32'(pending), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
  endtask

  initial begin
    model_reset();
    #2;
    ticks(2);
    check_reset_lit("reset");
    rst_n = 1'b1;
    tick();

    // held 3U -> one lamp at N, one entry at N+1
    btn = 6'b000100;
    tick();
    check("lit_3u_lamp", 32'(pending), 32'b000100);
    check("lit_3u_cnt_N", 32'(count), 32'h0);
    tick();
    check("lit_3u_cnt", 32'(count), 32'h1);
    check("lit_3u_req", 32'(req), 32'b011);
    check("lit_3u_nempty", 32'(qEmpty), 32'h0);
    tick();
    check("lit_3u_held", 32'(count), 32'h1);
    btn = 6'b0; tick();
    done = 1'b1; tick();
    done = 1'b0; tick();

    // 1U and 4D together: 1U first
    btn = 6'b100001; tick();
    btn = 6'b0; ticks(2);
    check("lit_pair_req", 32'(req), 32'b001);
    check("lit_pair_cnt", 32'(count), 32'h2);
    done = 1'b1; tick();
    check("lit_pop_req", 32'(req), 32'b100);
    check("lit_pop_cnt", 32'(count), 32'h1);
    check("lit_pop_pend", 32'(pending), 32'b100000);
    done = 1'b0; tick();
    done = 1'b1; tick();
    done = 1'b0; tick();

    // 2D dedup, and press lost when coinciding with its own pop
    btn = 6'b001000; tick();
    btn = 6'b0; tick();
    btn = 6'b001000; tick();
    btn = 6'b0; tick();
    check("lit_dedup_cnt", 32'(count), 32'h1);
    check("lit_dedup_pend", 32'(pending), 32'b001000);
    btn = 6'b001000; done = 1'b1; tick();
    check("lit_lost_cnt", 32'(count), 32'h0);
    check("lit_lost_pend", 32'(pending), 32'h0);
    tick();
    check("lit_lost_held", 32'(count), 32'h0);
    btn = 6'b0; done = 1'b0; tick();

    // done held high: exactly one pop
    btn = 6'b000111; tick();
    btn = 6'b0; ticks(3);
    check("lit_three", 32'(count), 32'h3);
    done = 1'b1; ticks(5);
    check("lit_held_done", 32'(count), 32'h2);
    for (int k = 0; k < 2; k++) begin
      done = 1'b0; tick();
      done = 1'b1; tick();
    end
    done = 1'b0; tick();
    done = 1'b1; tick();
    check("lit_empty_done_cnt", 32'(count), 32'h0);
    check("lit_empty_done_qe", 32'(qEmpty), 32'h1);
    done = 1'b0; tick();

    // fill all codes, async reset with done high
    btn = 6'b111111; tick();
    btn = 6'b0; ticks(6);
    check("lit_full6", 32'(count), 32'h6);
    done = 1'b1; tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_lit("async_rst");
    ticks(2);
    rst_n = 1'b1;
    btn = 6'b000001; tick();
    btn = 6'b0; tick();
    check("lit_post_rst_cnt", 32'(count), 32'h1);
    tick();
    check("lit_no_false_pop", 32'(count), 32'h1);
    done = 1'b0; tick();
    done = 1'b1; tick();
    check("lit_real_pop", 32'(count), 32'h0);
    done = 1'b0; tick();

    // random phase
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) btn = 6'($urandom_range(0, 63));
      else btn = btn & 6'($urandom_range(0, 63));
      done = ($urandom_range(0, 2) == 0);
      if (c == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
